// File: rtl/interface_sensor_distancia_bcd.sv
// Ultrasonic (HC-SR04 style) distance interface.
// Fires a trigger pulse, times the echo pulse, and presents the distance in cm
// as three registered BCD digits (centenas/dezenas/unidades).
// Handshake: medir is a level request sampled only while idle; pronto/erro are
// single-cycle completion strobes (mutually exclusive); ocupado is high while a
// measurement is in flight. There is no backpressure.
module interface_sensor_distancia_bcd #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1_900_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       medir,
    input  logic       echo,
    output logic       trigger,
    output logic [3:0] unidades,
    output logic [3:0] dezenas,
    output logic [3:0] centenas,
    output logic       pronto,
    output logic       erro,
    output logic       ocupado,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIGGER   = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_MEASURE   = 3'd3,
        S_STORE     = 3'd4,
        S_ABORT     = 3'd5
    } state_t;

    // One counter serves both the trigger width and the echo timeouts.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIGGER_CYCLES) ? TIMEOUT_CYCLES : TRIGGER_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIGGER_CYCLES - 1);
    localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CYCLES_PER_CM - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tick;
    logic [3:0]    acc_u, acc_d, acc_c;
    logic [3:0]    inc_u, inc_d, inc_c;
    logic          echo_meta, echo_sync, echo_prev;
    logic          echo_rise, echo_fall;

    // Two-flop synchronizer plus a delay flop for edge detection; rise and fall
    // see the same latency so the measured width is preserved.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_sync;
        end
    end

    assign echo_rise = echo_sync & ~echo_prev;
    assign echo_fall = ~echo_sync & echo_prev;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state and output decode; outputs come straight from the state so an
    // async reset drops trigger immediately.
    always_comb begin
        state_next = state;
        trigger    = 1'b0;
        pronto     = 1'b0;
        erro       = 1'b0;
        ocupado    = 1'b1;
        case (state)
            S_IDLE: begin
                ocupado = 1'b0;
                if (medir) state_next = S_TRIGGER;
            end
            S_TRIGGER: begin
                trigger = 1'b1;
                if (cnt == TRIG_LAST) state_next = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                if (echo_rise)             state_next = S_MEASURE;
                else if (cnt == TOUT_LAST) state_next = S_ABORT;
            end
            S_MEASURE: begin
                if (echo_fall)             state_next = S_STORE;
                else if (cnt == TOUT_LAST) state_next = S_ABORT;
            end
            S_STORE: begin
                pronto     = 1'b1;
                state_next = S_IDLE;
            end
            S_ABORT: begin
                erro       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign estado = state;

    // BCD accumulator plus one, saturating at 999.
    always_comb begin
        inc_u = acc_u;
        inc_d = acc_d;
        inc_c = acc_c;
        if (!(acc_c == 4'd9 && acc_d == 4'd9 && acc_u == 4'd9)) begin
            if (acc_u == 4'd9) begin
                inc_u = 4'd0;
                if (acc_d == 4'd9) begin
                    inc_d = 4'd0;
                    inc_c = acc_c + 4'd1;
                end else begin
                    inc_d = acc_d + 4'd1;
                end
            end else begin
                inc_u = acc_u + 4'd1;
            end
        end
    end

    // Counters, BCD accumulator and output digit registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            tick     <= '0;
            acc_u    <= 4'd0;
            acc_d    <= 4'd0;
            acc_c    <= 4'd0;
            unidades <= 4'd0;
            dezenas  <= 4'd0;
            centenas <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (medir) begin
                        cnt   <= '0;
                        tick  <= '0;
                        acc_u <= 4'd0;
                        acc_d <= 4'd0;
                        acc_c <= 4'd0;
                    end
                end
                S_TRIGGER: begin
                    cnt <= (cnt == TRIG_LAST) ? '0 : cnt + CW'(1);
                end
                S_WAIT_ECHO: begin
                    cnt <= echo_rise ? '0 : cnt + CW'(1);
                end
                S_MEASURE: begin
                    // Every MEASURE cycle, including the one that sees the fall,
                    // is one clock of echo-high time.
                    cnt <= cnt + CW'(1);
                    if (tick == TICK_LAST) begin
                        tick  <= '0;
                        acc_u <= inc_u;
                        acc_d <= inc_d;
                        acc_c <= inc_c;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                S_STORE: begin
                    unidades <= acc_u;
                    dezenas  <= acc_d;
                    centenas <= acc_c;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
